pattern_source_64: RTL and testbench

PATTERN_SOURCE_64 -- requirements
Module: pattern_source_64

---
 rtl/pattern_pkg.sv | 41 ++++
 rtl/lfsr32_step2.sv | 17 +
 rtl/pattern_source_64.sv | 167 ++++++++++++++++
 tb/tb_pattern_source_64.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the 64-bit pattern source.
//   - mode codes selected by pattern[2:0]
//   - generator state enumeration
//   - LFSR seed, tap mask and single-step helper
//   - FIXED-mode constants
//   - beat payload layout (hi = element n+1, lo = element n)
package pattern_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEAT_W = 2 * DATA_W;
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_COUNTER = 3'd0;
  localparam logic [MODE_W-1:0] MODE_WALK1   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LFSR    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_FIXED   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci LFSR x^32 + x^22 + x^2 + x + 1: taps on bits 31, 21, 1, 0
  localparam logic [DATA_W-1:0] LFSR_SEED = 32'h0000_0001;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [DATA_W-1:0] FIXED_EVEN = 32'hA5A5_5A5A;
  localparam logic [DATA_W-1:0] FIXED_ODD  = 32'h5A5A_A5A5;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } beat_t;

  // One LFSR shift: feedback parity of tapped bits enters at bit 0
  function automatic logic [DATA_W-1:0] lfsr_shift(input logic [DATA_W-1:0] s);
    return {s[DATA_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr32_step2.sv
// lfsr32_step2: combinational two-step advance of the 32-bit pattern LFSR.
// Ports:
//   state    in  32  current LFSR value (element n)
//   step1_c  out 32  value after one shift (element n+1)
//   step2_c  out 32  value after two shifts (next beat's element n)
module lfsr32_step2
  import pattern_pkg::*;
(
  input  logic [DATA_W-1:0] state,
  output logic [DATA_W-1:0] step1_c,
  output logic [DATA_W-1:0] step2_c
);

  assign step1_c = lfsr_shift(state);
  assign step2_c = lfsr_shift(step1_c);

endmodule

// File: rtl/pattern_source_64.sv
// pattern_source_64: burst-oriented 64-bit test pattern generator feeding a FIFO.
// Each beat carries two consecutive 32-bit elements (low half = earlier one).
// Modes: counter, walking one, LFSR, fixed A5/5A alternation; 4-7 act as counter.
// Optional feature: define PATTERN_LFSR_EN to build the LFSR mode; without it
// mode 2 behaves as the counter and no LFSR logic is present.
// Ports:
//   clk               in   1  clock, rising edge
//   reset             in   1  asynchronous active-high reset
//   pattern           in  32  [2:0] mode select, latched when the run starts
//   burst_len         in  32  beats per burst, 0 = unbounded, latched at start
//   enable_gener      in   1  advance request; low stalls generation
//   dataout           out 64  registered beat
//   dataout_available out  1  one-cycle strobe qualifying dataout
//   word_count        out 32  beats produced since reset, wrapping
//   done              out  1  high once the burst has completed
module pattern_source_64
  import pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pattern,
  input  logic [31:0]       burst_len,
  input  logic              enable_gener,
  output logic [63:0]       dataout,
  output logic              dataout_available,
  output logic [31:0]       word_count,
  output logic              done
);

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d, eff_mode_c;
  logic [DATA_W-1:0]   burst_q, burst_d, burst_eff_c;
  logic [DATA_W-1:0]   beat_cnt_q, beat_cnt_next_c;
  logic [DATA_W-1:0]   k_q, k1_c;
  logic                issue_c;
  beat_t               beat_c;

  logic [BEAT_W-1:0]   dataout_q;
  logic                avail_q;
  logic [DATA_W-1:0]   word_count_q;
  logic                done_q;

  // Upper pattern bits carry no meaning
  logic unused_pattern_bits;
  assign unused_pattern_bits = ^pattern[31:MODE_W];

  assign k1_c            = k_q + 32'd1;
  assign beat_cnt_next_c = beat_cnt_q + 32'd1;

`ifdef PATTERN_LFSR_EN
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_step1_c;
  logic [DATA_W-1:0] lfsr_step2_c;

  lfsr32_step2 u_lfsr (
    .state   (lfsr_q),
    .step1_c (lfsr_step1_c),
    .step2_c (lfsr_step2_c)
  );

  // LFSR state advances two shifts per issued beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (issue_c) begin
      lfsr_q <= lfsr_step2_c;
    end
  end
`endif

  // Next-state logic; the start cycle uses the live pattern/burst_len inputs
  // because the first beat is issued in the same cycle they are latched.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    burst_d     = burst_q;
    issue_c     = 1'b0;
    eff_mode_c  = mode_q;
    burst_eff_c = burst_q;
    case (state_q)
      ST_IDLE: begin
        eff_mode_c  = pattern[MODE_W-1:0];
        burst_eff_c = burst_len;
        if (enable_gener) begin
          issue_c = 1'b1;
          state_d = ST_RUN;
          mode_d  = pattern[MODE_W-1:0];
          burst_d = burst_len;
        end
      end
      ST_RUN: begin
        if (enable_gener) begin
          issue_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Bounded burst ends on the beat that reaches burst_len
    if (issue_c && (burst_eff_c != '0) && (beat_cnt_next_c == burst_eff_c)) begin
      state_d = ST_DONE;
    end
  end

  // Element pair for the current index k (k always even)
  always_comb begin
    beat_c.lo = k_q;
    beat_c.hi = k1_c;
    case (eff_mode_c)
      MODE_WALK1: begin
        beat_c.lo = DATA_W'(1) << k_q[4:0];
        beat_c.hi = DATA_W'(1) << k1_c[4:0];
      end
      MODE_FIXED: begin
        beat_c.lo = FIXED_EVEN;
        beat_c.hi = FIXED_ODD;
      end
`ifdef PATTERN_LFSR_EN
      MODE_LFSR: begin
        beat_c.lo = lfsr_q;
        beat_c.hi = lfsr_step1_c;
      end
`endif
      default: begin
        beat_c.lo = k_q;
        beat_c.hi = k1_c;
      end
    endcase
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COUNTER;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      k_q          <= '0;
      dataout_q    <= '0;
      avail_q      <= 1'b0;
      word_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      burst_q <= burst_d;
      avail_q <= issue_c;
      done_q  <= (state_d == ST_DONE);
      if (issue_c) begin
        beat_cnt_q   <= beat_cnt_next_c;
        k_q          <= k_q + 32'd2;
        dataout_q    <= beat_c;
        word_count_q <= word_count_q + 32'd1;
      end
    end
  end

  assign dataout           = dataout_q;
  assign dataout_available = avail_q;
  assign word_count        = word_count_q;
  assign done              = done_q;

endmodule

// File: tb/tb_pattern_source_64.sv
`timescale 1ns/1ps
module tb_pattern_source_64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pattern;
  logic [31:0] burst_len;
  logic        enable_gener;
  logic [63:0] dataout;
  logic        dataout_available;
  logic [31:0] word_count;
  logic        done;

  pattern_source_64 dut (
    .clk               (clk),
    .reset             (reset),
    .pattern           (pattern),
    .burst_len         (burst_len),
    .enable_gener      (enable_gener),
    .dataout           (dataout),
    .dataout_available (dataout_available),
    .word_count        (word_count),
    .done              (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] wc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_wc;

  localparam logic [63:0] FIXED_PAIR = 64'h5A5AA5A5_A5A55A5A;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d);
    exp_t e;
    exp_wc  = exp_wc + 32'd1;
    e.data  = d;
    e.wc    = exp_wc;
    sb.push_back(e);
  endtask

  // Drive enable for one clock; returns 1 time unit after the rising edge
  task automatic step(input logic en);
    enable_gener = en;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    enable_gener = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_wc = '0;
  endtask

  function automatic logic [31:0] walk(input int unsigned idx);
    logic [31:0] one;
    one = 32'd1;
    return one << (idx % 32);
  endfunction

  function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected beat
  initial begin
    forever begin
      @(negedge clk);
      if (dataout_available === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got 0x%016h expected no strobe", dataout);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", dataout, mon_e.data);
          check("beat_wc", 64'(word_count), 64'(mon_e.wc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] t1 [6];
  logic        t4 [7];
  logic [31:0] s;

  initial begin
    reset        = 1'b1;
    pattern      = 32'd0;
    burst_len    = 32'd0;
    enable_gener = 1'b0;
    exp_wc       = '0;
    t1 = '{64'h00000001_00000000, 64'h00000003_00000002, 64'h00000005_00000004,
           64'h00000007_00000006, 64'h00000009_00000008, 64'h0000000B_0000000A};
    t4 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_dataout", dataout, 64'd0);
    check("reset_avail", 64'(dataout_available), 64'd0);
    check("reset_wc", 64'(word_count), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Counter mode, unbounded, four beats then a stall then two more
    pattern   = 32'hFFFF_FFF8;  // mode bits 0, upper bits ignored
    burst_len = 32'd0;
    for (int i = 0; i < 4; i++) begin
      push(t1[i]);
      step(1'b1);
    end
    step(1'b0);
    check("stall_hold", dataout, 64'h00000007_00000006);
    check("stall_strobe", 64'(dataout_available), 64'd0);
    check("wc_after4", 64'(word_count), 64'd4);
    for (int i = 4; i < 6; i++) begin
      push(t1[i]);
      step(1'b1);
    end
    step(1'b0);
    drain("drain_counter");
    check("counter_not_done", 64'(done), 64'd0);

    // Walking one, 17 beats; beat 16 wraps k to 32/33
    do_reset();
    pattern = 32'd1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) push(64'h00000002_00000001);
      else         push({walk(2 * i + 1), walk(2 * i)});
      step(1'b1);
    end
    step(1'b0);
    drain("drain_walk");
    check("wc_walk", 64'(word_count), 64'd17);

    // Mode 2: LFSR when built with the feature, counter otherwise
    do_reset();
    pattern = 32'd2;
    s = 32'h0000_0001;
    for (int i = 0; i < 1000; i++) begin
`ifdef PATTERN_LFSR_EN
      if (i == 0)      push(64'h00000003_00000001);
      else if (i == 1) push(64'h0000000D_00000006);
      else             push({lfsr_ref(s), s});
      s = lfsr_ref(lfsr_ref(s));
`else
      push({32'(2 * i + 1), 32'(2 * i)});
`endif
      step(1'b1);
    end
    step(1'b0);
    drain("drain_mode2");
    check("wc_mode2", 64'(word_count), 64'd1000);

    // Fixed mode, burst of 3 with gaps; burst_len change after start ignored
    do_reset();
    pattern   = 32'd3;
    burst_len = 32'd3;
    for (int i = 0; i < 7; i++) begin
      if (t4[i] && (i == 0 || i == 2 || i == 4)) push(FIXED_PAIR);
      step(t4[i]);
      if (i == 0) burst_len = 32'd0;
      if (i == 4) check("done_after_third", 64'(done), 64'd1);
    end
    step(1'b0);
    drain("drain_fixed");
    check("fixed_done", 64'(done), 64'd1);
    check("fixed_wc", 64'(word_count), 64'd3);
    check("fixed_hold", dataout, FIXED_PAIR);
    repeat (3) step(1'b1);
    step(1'b0);
    check("done_sticky", 64'(done), 64'd1);
    check("done_no_more", 64'(word_count), 64'd3);

    // Reset mid-burst with pattern switched to FIXED while in reset
    do_reset();
    pattern   = 32'd0;
    burst_len = 32'd0;
    for (int i = 0; i < 5; i++) begin
      push(t1[i]);
      step(1'b1);
    end
    step(1'b0);
    drain("drain_pre_reset");
    enable_gener = 1'b1;          // beat in flight, not expected
    @(posedge clk);
    #1;
    reset   = 1'b1;
    pattern = 32'd3;
    #1;
    check("midreset_dataout", dataout, 64'd0);
    check("midreset_avail", 64'(dataout_available), 64'd0);
    check("midreset_wc", 64'(word_count), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    enable_gener = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_wc = '0;
    push(FIXED_PAIR);
    step(1'b1);
    push(FIXED_PAIR);
    step(1'b1);
    step(1'b0);
    drain("drain_post_reset");
    check("post_reset_wc", 64'(word_count), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
